// File: rtl/x3q16_uart_tx.sv
// Word-oriented 8N1 UART transmitter for the x3q16 core: pushed 16-bit words are
// buffered in a FIFO and sent as two back-to-back frames, low byte first.
module x3q16_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             uart_send,
  input  logic [15:0]      data_in,
  output logic             tx,
  output logic             busy,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [15:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;

  state_t            r_state;
  logic              r_tx;
  logic [7:0]        r_shift;
  logic [7:0]        r_highByte;
  logic              r_byteSel;
  logic [2:0]        r_bitCnt;
  logic [BAUD_W-1:0] r_baud;

  state_t            w_nextState;
  logic              w_nextTx;
  logic [7:0]        w_nextShift;
  logic [7:0]        w_nextHigh;
  logic              w_nextByteSel;
  logic [2:0]        w_nextBitCnt;
  logic [BAUD_W-1:0] w_nextBaud;
  logic              w_pop;
  logic              w_push;
  logic              w_baudDone;
  logic [15:0]       w_head;
  logic [CNT_W-1:0]  w_nextCount;

  assign w_head     = r_mem[r_rdPtr];
  assign w_baudDone = (r_baud == BAUD_LAST);
  // A full FIFO still accepts a push when the transmitter pops on the same edge.
  assign w_push     = uart_send & (~r_full | w_pop);

  always_comb begin
    w_nextCount = r_count;
    case ({w_push, w_pop})
      2'b10:   w_nextCount = r_count + CNT_W'(1);
      2'b01:   w_nextCount = r_count - CNT_W'(1);
      default: w_nextCount = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= w_nextCount;
      r_full  <= (w_nextCount == DEPTH_CNT);
      r_empty <= (w_nextCount == '0);
      if (uart_send && r_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_highByte <= '0;
      r_byteSel  <= 1'b0;
      r_bitCnt   <= '0;
      r_baud     <= '0;
    end else begin
      r_state    <= w_nextState;
      r_tx       <= w_nextTx;
      r_shift    <= w_nextShift;
      r_highByte <= w_nextHigh;
      r_byteSel  <= w_nextByteSel;
      r_bitCnt   <= w_nextBitCnt;
      r_baud     <= w_nextBaud;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextTx      = r_tx;
    w_nextShift   = r_shift;
    w_nextHigh    = r_highByte;
    w_nextByteSel = r_byteSel;
    w_nextBitCnt  = r_bitCnt;
    w_nextBaud    = r_baud;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextTx = 1'b1;
        if (!r_empty) begin
          w_pop         = 1'b1;
          w_nextShift   = w_head[7:0];
          w_nextHigh    = w_head[15:8];
          w_nextByteSel = 1'b0;
          w_nextTx      = 1'b0;
          w_nextBaud    = '0;
          w_nextState   = START;
        end
      end
      START: begin
        if (w_baudDone) begin
          w_nextState  = DATA;
          w_nextTx     = r_shift[0];
          w_nextBitCnt = '0;
          w_nextBaud   = '0;
        end else begin
          w_nextBaud = r_baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (w_baudDone) begin
          w_nextBaud = '0;
          if (r_bitCnt == 3'd7) begin
            w_nextState = STOP;
            w_nextTx    = 1'b1;
          end else begin
            w_nextShift  = {1'b0, r_shift[7:1]};
            w_nextTx     = r_shift[1];
            w_nextBitCnt = r_bitCnt + 3'd1;
          end
        end else begin
          w_nextBaud = r_baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (w_baudDone) begin
          w_nextBaud = '0;
          // High byte follows with no gap; then chain straight into the next word if one waits.
          if (!r_byteSel) begin
            w_nextShift   = r_highByte;
            w_nextByteSel = 1'b1;
            w_nextTx      = 1'b0;
            w_nextState   = START;
          end else if (!r_empty) begin
            w_pop         = 1'b1;
            w_nextShift   = w_head[7:0];
            w_nextHigh    = w_head[15:8];
            w_nextByteSel = 1'b0;
            w_nextTx      = 1'b0;
            w_nextState   = START;
          end else begin
            w_nextState = IDLE;
          end
        end else begin
          w_nextBaud = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextTx    = 1'b1;
      end
    endcase
  end

  assign tx         = r_tx;
  assign busy       = (r_state != IDLE) | ~r_empty;
  assign fifo_full  = r_full;
  assign fifo_empty = r_empty;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: doc/x3q16_uart_tx.md
Name: x3q16_uart_tx

Overview:
Word-oriented UART transmitter that consumes the x3q16 core's UART call output (uart_send strobe with the word on data_out). Each accepted 16-bit word is buffered in a small FIFO and serialised as two back-to-back 8N1 frames, low byte first. Status outputs let software and top-level logic see backlog and dropped words.

Parameters:
CLKS_PER_BIT, 104, clock cycles per serial bit; legal range >= 2
FIFO_DEPTH, 8, word entries; power of two, >= 2
CNT_W, 4, width of fifo_count; must equal log2(FIFO_DEPTH)+1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
uart_send  input  1  push strobe from core; one word accepted per high cycle
data_in  input  16  word to transmit; connects to core data_out, sampled when uart_send=1
tx  output  1  serial line, idle high
busy  output  1  1 when a frame is in progress or the FIFO is non-empty
fifo_full  output  1  count == FIFO_DEPTH
fifo_empty  output  1  count == 0
fifo_count  output  CNT_W  words currently buffered, excluding the word being shifted
overflow  output  1  sticky; set when a push is dropped

Behaviour:
- Reset (async, active-high): tx=1, busy=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0. FIFO pointers cleared, FSM to IDLE. Reset mid-frame aborts the frame immediately, tx returns high asynchronously, and buffered words are discarded.
- Push: on a rising edge with uart_send=1:
  - Not full: data_in is written at the write pointer, which advances mod FIFO_DEPTH.
  - Full with a pop on the same edge: the push is accepted and the count is unchanged.
  - Full with no pop: the word is dropped and overflow is set to 1. overflow is cleared only by reset.
- Each cycle uart_send is high is a separate push. The core holds it for exactly one cycle.
- FSM states: IDLE, START, DATA, STOP. Additional registers:
  - 8-bit shift register
  - 8-bit saved high byte
  - byte_sel (0 = low byte, 1 = high byte)
  - bit counter 0..7
  - baud counter 0..CLKS_PER_BIT-1
- IDLE:
  - tx=1.
  - If the FIFO is non-empty at an edge: pop the head word, load the shift register with [7:0], save [15:8], set byte_sel=0, tx<=0, go to START, baud counter=0.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA, drive tx<=shift[0], bit counter=0.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles. The shift register shifts right, LSB first.
  - After bit 7 completes, go to STOP with tx<=1.
- STOP: hold tx=1 for CLKS_PER_BIT cycles, then:
  - byte_sel=0: load the saved high byte, set byte_sel=1, tx<=0, go to START. There is no idle gap.
  - byte_sel=1 and FIFO non-empty: pop the next word and go to START directly, back-to-back.
  - Otherwise: go to IDLE.
- Latency: a push at edge N into an empty FIFO while IDLE causes tx to fall at edge N+1. A word occupies exactly 20*CLKS_PER_BIT cycles of line time.
- fifo_count, fifo_full and fifo_empty are registered and consistent with the pointers every cycle. A simultaneous push and pop when not full or empty leaves the count unchanged.
- Pointers wrap mod FIFO_DEPTH. Full and empty are distinguished by the count, not by pointer equality.
- busy = (state != IDLE) | ~fifo_empty.

Test Plan:
- Reset, then CLKS_PER_BIT=4, push 16'hA55A once. Expected on tx:
  - tx falls 1 clock after the push.
  - Low frame: 0, then 0,1,0,1,1,0,1,0, then 1 (byte 0x5A).
  - High frame immediately after: 0, then 1,0,1,0,0,1,0,1, then 1 (byte 0xA5).
  - Each bit is 4 cycles, 80 cycles total. busy drops on the cycle tx returns to IDLE.
- Push 3 words on consecutive cycles (0x0001, 0x0002, 0x0003) -> fifo_count peaks at 2. Six frames are sent with no idle gap, 240 cycles total at CLKS_PER_BIT=4. fifo_empty=1 at the end.
- With FIFO_DEPTH=8 and the line busy, push 10 words -> fifo_full=1 after the 9th push (8 buffered plus 1 shifting). The 10th push is dropped and overflow=1. The dropped word never appears on tx, and overflow stays 1 afterwards.
- FIFO full, then push on the same edge as a STOP-to-START pop -> the push is accepted, fifo_count stays 8, overflow stays 0.
- Reset asserted mid-DATA of the high byte -> tx=1 immediately (before the next clock edge), fifo_count=0. After release, no residual frames are emitted.
- Write 20 words in groups so the pointers wrap twice -> the transmitted byte sequence matches the pushes in order.
